wb_dma_master: RTL

- Wishbone classic initiator that moves blocks of 32-bit words between local ready/valid streams and a Wishbone responder (e.g. the accelerator's register/SRAM window at 0x3000_0000).
- Firmware-side or test-harness-side counterpart of the accelerator slave: loads matrix operands, writes the operation/status registers, then reads results back.
- Issues single transfers only, one word per bus cycle; the address advances by 4 per word.

---
 rtl/wb_dma_master_pkg.sv | 27 ++
 rtl/wb_dma_master.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/wb_dma_master_pkg.sv
// rtl/wb_dma_master_pkg.sv - shared encodings and constants for wb_dma_master
package wb_dma_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_BUS   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_GAP   = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  localparam logic [3:0]  WB_SEL_ALL  = 4'b1111;
  localparam logic [31:0] WORD_STRIDE = 32'd4;
  localparam logic [31:0] WORD_MASK   = 32'h0000_0003;

  // Accelerator register window offsets
  localparam logic [31:0] ACC_OPERATION_OFS = 32'h0000_0000;
  localparam logic [31:0] ACC_STATUS_OFS    = 32'h0000_0004;
  localparam logic [31:0] ACC_SRAM_OFS      = 32'h0000_0008;
  localparam logic [31:0] STATUS_START      = 32'hFFFF_FFFF;

  function automatic logic [31:0] word_align(input logic [31:0] byte_addr);
    return byte_addr & ~WORD_MASK;
  endfunction

endpackage

// File: rtl/wb_dma_master.sv
// rtl/wb_dma_master.sv - Wishbone classic block-transfer initiator between local streams and a responder
// Optional per-transfer ack timeout enabled by defining WB_TIMEOUT_EN.
module wb_dma_master #(
  parameter int LEN_W          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_write_i,
  input  logic [31:0]      cmd_addr_i,
  input  logic [LEN_W-1:0] cmd_len_i,
  input  logic             wdata_valid_i,
  output logic             wdata_ready_o,
  input  logic [31:0]      wdata_i,
  output logic             rdata_valid_o,
  input  logic             rdata_ready_i,
  output logic [31:0]      rdata_o,
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  output logic             wb_we_o,
  output logic [3:0]       wb_sel_o,
  output logic [31:0]      wb_adr_o,
  output logic [31:0]      wb_dat_o,
  input  logic [31:0]      wb_dat_i,
  input  logic             wb_ack_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);
  import wb_dma_master_pkg::*;

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end
  if (LEN_W < 1) begin : g_len_check
    $error("LEN_W must be at least 1");
  end

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             dir_q, dir_d;
  logic [31:0]      dat_q, dat_d;
  logic [31:0]      rdata_q, rdata_d;

`ifdef WB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
  logic             tmo_hit;

  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    dat_d   = dat_q;
    rdata_d = rdata_q;
`ifdef WB_TIMEOUT_EN
    err_d   = err_q;
    // Counts cycles spent in BUS; any other state holds it at zero
    tmo_d   = (state_q == ST_BUS) ? tmo_q + 1'b1 : '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          addr_d = word_align(cmd_addr_i);
          rem_d  = cmd_len_i;
          dir_d  = cmd_write_i;
`ifdef WB_TIMEOUT_EN
          err_d  = 1'b0;
`endif
          if (cmd_len_i == '0)   state_d = ST_DONE;
          else if (cmd_write_i)  state_d = ST_FETCH;
          else                   state_d = ST_BUS;
        end
      end
      ST_FETCH: begin
        if (wdata_valid_i) begin
          dat_d   = wdata_i;
          state_d = ST_BUS;
        end
      end
      ST_BUS: begin
        if (wb_ack_i) begin
          if (!dir_q) rdata_d = wb_dat_i;
          state_d = dir_q ? ST_GAP : ST_DRAIN;
        end
`ifdef WB_TIMEOUT_EN
        else if (tmo_hit) begin
          // Leave exactly one word outstanding so GAP terminates the job
          err_d   = 1'b1;
          rem_d   = LEN_W'(1);
          state_d = ST_GAP;
        end
`endif
      end
      ST_DRAIN: begin
        if (rdata_ready_i) state_d = ST_GAP;
      end
      ST_GAP: begin
        // The responder may still be driving ack from the finished cycle
        if (!wb_ack_i) begin
          rem_d  = rem_q - LEN_W'(1);
          addr_d = addr_q + WORD_STRIDE;
          if (rem_q == LEN_W'(1)) state_d = ST_DONE;
          else if (dir_q)         state_d = ST_FETCH;
          else                    state_d = ST_BUS;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      dat_q   <= '0;
      rdata_q <= '0;
`ifdef WB_TIMEOUT_EN
      tmo_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      dat_q   <= dat_d;
      rdata_q <= rdata_d;
`ifdef WB_TIMEOUT_EN
      tmo_q   <= tmo_d;
      err_q   <= err_d;
`endif
    end
  end

  assign cmd_ready_o   = (state_q == ST_IDLE);
  assign busy_o        = (state_q != ST_IDLE);
  assign wdata_ready_o = (state_q == ST_FETCH);
  assign rdata_valid_o = (state_q == ST_DRAIN);
  assign rdata_o       = rdata_q;
  assign wb_cyc_o      = (state_q == ST_BUS);
  assign wb_stb_o      = (state_q == ST_BUS);
  assign wb_we_o       = (state_q == ST_BUS) && dir_q;
  assign wb_sel_o      = (state_q == ST_BUS) ? WB_SEL_ALL : 4'b0000;
  assign wb_adr_o      = addr_q;
  assign wb_dat_o      = dat_q;
  assign done_o        = (state_q == ST_DONE);
`ifdef WB_TIMEOUT_EN
  assign err_o         = err_q;
`else
  assign err_o         = 1'b0;
`endif

endmodule
